// File: rtl/exp6_detector_jogada.sv
// exp6_detector_jogada
//   Debounces four raw player buttons and turns each accepted press into a
//   single-cycle "jogada" pulse. The one-hot code of the accepted button is
//   latched on botao_codigo. A button that is held produces only one pulse.
//   The buttons must then stay released for a full debounce window before
//   another press is accepted.
//
//   Optional feature macro: DETECTOR_MULTIPLO_EN
//     defined   -> a debounced pattern with more than one bit set is rejected.
//                  invalida pulses for one cycle, and botao_codigo is left
//                  unchanged.
//     undefined -> a multi-bit pattern is reduced to its lowest-index set bit
//                  and accepted as a normal press. invalida is tied to 0.
//
// Ports
//   clock        in   rising-edge system clock
//   reset_n      in   asynchronous, active-low reset
//   botoes[3:0]  in   raw, asynchronous, bouncing, active-high buttons
//   habilita     in   controller is waiting for a play
//   jogada       out  one-cycle pulse per accepted press
//   botao_codigo out  one-hot code of the last accepted button
//   invalida     out  one-cycle pulse on a rejected multi-button press
//   db_estado    out  current FSM state code (debug)
module exp6_detector_jogada #(
  parameter int DEB_CICLOS = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic       jogada,
  output logic [3:0] botao_codigo,
  output logic       invalida,
  output logic [2:0] db_estado
);

  localparam int CW = (DEB_CICLOS > 2) ? $clog2(DEB_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_FIM = CW'(DEB_CICLOS - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    OCIOSO         = 3'd0,
    DEB_APERTO     = 3'd1,
    PULSO          = 3'd2,
    AGUARDA_SOLTAR = 3'd3,
    DEB_SOLTURA    = 3'd4
  } estado_t;

  estado_t       state_q, state_d;
  logic [3:0]    sync1_q, bs_q;
  logic [3:0]    snap_q, snap_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          jogada_q, jogada_d;
  logic [3:0]    codigo_q, codigo_d;
  logic [3:0]    snap_lsb;
  logic          snap_multi;
  logic          invalida_d;

  // Saturating increment, so a long window can never wrap back to zero.
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  // Isolate the lowest set bit, and flag patterns with two or more bits set.
  assign snap_lsb   = snap_q & (~snap_q + 4'd1);
  assign snap_multi = (snap_q & (snap_q - 4'd1)) != 4'd0;

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    cnt_d      = cnt_q;
    invalida_d = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (bs_q != 4'd0) begin
          snap_d  = bs_q;
          cnt_d   = '0;
          state_d = DEB_APERTO;
        end
      end
      DEB_APERTO: begin
        if (bs_q == 4'd0) begin
          cnt_d   = '0;
          state_d = OCIOSO;
        end else if (bs_q != snap_q) begin
          // The pattern changed while still bouncing: restart the window.
          snap_d = bs_q;
          cnt_d  = '0;
        end else if (cnt_q >= CNT_FIM) begin
          // habilita is looked at only here, at the end of the window.
          cnt_d = '0;
          if (habilita) begin
`ifdef DETECTOR_MULTIPLO_EN
            if (snap_multi) begin
              invalida_d = 1'b1;
              state_d    = AGUARDA_SOLTAR;
            end else begin
              state_d = PULSO;
            end
`else
            state_d = PULSO;
`endif
          end else begin
            state_d = AGUARDA_SOLTAR;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PULSO: begin
        cnt_d   = '0;
        state_d = AGUARDA_SOLTAR;
      end
      AGUARDA_SOLTAR: begin
        if (bs_q == 4'd0) begin
          cnt_d   = '0;
          state_d = DEB_SOLTURA;
        end
      end
      DEB_SOLTURA: begin
        if (bs_q != 4'd0) begin
          cnt_d   = '0;
          state_d = AGUARDA_SOLTAR;
        end else if (cnt_q >= CNT_FIM) begin
          cnt_d   = '0;
          state_d = OCIOSO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = OCIOSO;
      end
    endcase

    // Outputs are registered alongside the state, so jogada and the new
    // code are both visible in the cycle the FSM sits in PULSO.
    jogada_d = (state_d == PULSO);
    codigo_d = codigo_q;
    if (state_d == PULSO && state_q != PULSO) begin
      codigo_d = snap_lsb;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 4'd0;
      bs_q     <= 4'd0;
      state_q  <= OCIOSO;
      snap_q   <= 4'd0;
      cnt_q    <= '0;
      jogada_q <= 1'b0;
      codigo_q <= 4'd0;
    end else begin
      sync1_q  <= botoes;
      bs_q     <= sync1_q;
      state_q  <= state_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      jogada_q <= jogada_d;
      codigo_q <= codigo_d;
    end
  end

`ifdef DETECTOR_MULTIPLO_EN
  logic invalida_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      invalida_q <= 1'b0;
    end else begin
      invalida_q <= invalida_d;
    end
  end
  assign invalida = invalida_q;
`else
  logic unused_multi;
  assign unused_multi = snap_multi ^ invalida_d;
  assign invalida     = 1'b0;
`endif

  assign jogada       = jogada_q;
  assign botao_codigo = codigo_q;
  assign db_estado    = state_q;

endmodule

// File: tb/tb_exp6_detector_jogada.sv
module tb_exp6_detector_jogada;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] botoes;
  logic       habilita;
  logic       jogada;
  logic [3:0] botao_codigo;
  logic       invalida;
  logic [2:0] db_estado;

  int checks = 0;
  int errors = 0;
  int npulse, first, ninv, acc;
  logic [3:0] pcode;
  logic [2:0] st_log [1:256];

  exp6_detector_jogada #(.DEB_CICLOS(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .botoes(botoes),
    .habilita(habilita),
    .jogada(jogada),
    .botao_codigo(botao_codigo),
    .invalida(invalida),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Runs n cycles; cycle i is observed 1 ns after the i-th rising edge
  // following the last input change.
  task automatic run(input int n);
    npulse = 0; first = 0; ninv = 0; pcode = 4'hx;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock); #1;
      st_log[i] = db_estado;
      if (jogada === 1'b1) begin
        npulse++;
        if (first == 0) begin
          first = i;
          pcode = botao_codigo;
        end
      end
      if (invalida === 1'b1) ninv++;
    end
  endtask

  task automatic show(input string name);
    $display("%s: pulses=%0d first=%0d code=%b invalida=%0d", name, npulse, first, pcode, ninv);
  endtask

  initial begin
    reset_n = 1'b0; botoes = 4'd0; habilita = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_estado", db_estado, 3'd0);
    chk("rst_jogada", jogada, 1'b0);
    chk("rst_codigo", botao_codigo, 4'd0);
    chk("rst_invalida", invalida, 1'b0);
    reset_n = 1'b1;

    // Single press
    habilita = 1'b1; botoes = 4'b0100;
    run(20); show("single");
    chk("single_count", npulse, 1);
    chk("single_lat", first, 7);
    chk("single_code", pcode, 4'b0100);
    chk("single_st3", st_log[3], 3'd1);
    chk("single_st7", st_log[7], 3'd2);
    chk("single_st8", st_log[8], 3'd3);
    botoes = 4'd0; run(10); show("release");
    chk("release_pulses", npulse, 0);
    chk("release_idle", st_log[10], 3'd0);

    // Bounce
    acc = 0;
    for (int s = 0; s < 4; s++) begin
      botoes = (s % 2 == 0) ? 4'b0100 : 4'b0000;
      run(2);
      acc += npulse;
    end
    botoes = 4'b0100; run(20); show("bounce");
    chk("bounce_none", acc, 0);
    chk("bounce_count", npulse, 1);
    chk("bounce_lat", first, 7);
    botoes = 4'd0; run(10);

    // Disabled
    habilita = 1'b0; botoes = 4'b0001;
    run(20); show("disabled");
    chk("dis_pulses", npulse, 0);
    chk("dis_code", botao_codigo, 4'b0100);
    chk("dis_st8", st_log[8], 3'd3);
    botoes = 4'd0; run(10);
    habilita = 1'b1; botoes = 4'b0001;
    run(20); show("enabled");
    chk("en_count", npulse, 1);
    chk("en_lat", first, 7);
    chk("en_code", pcode, 4'b0001);
    botoes = 4'd0; run(10);

    // habilita rises mid-debounce: sampled at completion
    habilita = 1'b0; botoes = 4'b0010;
    run(5); acc = npulse;
    habilita = 1'b1;
    run(15); show("late_enable");
    chk("late_none_early", acc, 0);
    chk("late_count", npulse, 1);
    chk("late_lat", first, 2);
    chk("late_code", pcode, 4'b0010);
    botoes = 4'd0; run(10);

    // Hold and repress
    botoes = 4'b1000; run(100); show("hold");
    chk("hold_count", npulse, 1);
    chk("hold_lat", first, 7);
    chk("hold_code", pcode, 4'b1000);
    botoes = 4'd0; run(2); acc = npulse;
    botoes = 4'b1000; run(30); show("short_release");
    chk("short_rel_none", acc + npulse, 0);
    botoes = 4'd0; run(10);
    botoes = 4'b1000; run(20); show("repress");
    chk("repress_count", npulse, 1);
    chk("repress_lat", first, 7);
    botoes = 4'd0; run(10);

    // Multi-press
    botoes = 4'b0011; run(20); show("multi");
`ifdef DETECTOR_MULTIPLO_EN
    chk("multi_inv", ninv, 1);
    chk("multi_pulses", npulse, 0);
    chk("multi_code", botao_codigo, 4'b1000);
`else
    chk("multi_inv", ninv, 0);
    chk("multi_pulses", npulse, 1);
    chk("multi_lat", first, 7);
    chk("multi_code", pcode, 4'b0001);
`endif
    botoes = 4'd0; run(10);

    // Reset in the middle of a debounce
    botoes = 4'b0100; run(5);
    chk("mid_st", st_log[5], 3'd1);
    #2 reset_n = 1'b0;
    #1;
    $display("mid_reset: estado=%0d jogada=%b code=%b", db_estado, jogada, botao_codigo);
    chk("mid_rst_estado", db_estado, 3'd0);
    chk("mid_rst_jogada", jogada, 1'b0);
    chk("mid_rst_code", botao_codigo, 4'd0);
    chk("mid_rst_inv", invalida, 1'b0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    run(20); show("after_reset");
    chk("after_rst_count", npulse, 1);
    chk("after_rst_lat", first, 7);
    chk("after_rst_code", pcode, 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
